// File: rtl/led_status_pkg.sv
// Shared types and constants for the multi-channel status-LED controller.
package led_status_pkg;

  typedef enum logic [2:0] {
    LED_OFF     = 3'd0,
    LED_ON      = 3'd1,
    LED_BLINK   = 3'd2,
    LED_PWM     = 3'd3,
    LED_STRETCH = 3'd4,
    LED_BREATHE = 3'd5
  } led_mode_t;

  localparam int unsigned SIM_PRESCALE = 4;

endpackage

// File: rtl/led_channel.sv
// One LED channel: stored mode/level, event stretch counter and the
// registered, polarity-corrected LED drive.
module led_channel
  import led_status_pkg::*;
#(
  parameter int unsigned PWM_BITS      = 4,
  parameter int unsigned STRETCH_TICKS = 50,
  parameter int unsigned ACTIVE_LOW    = 1
) (
  input  logic                clk_50m,
  input  logic                rst,
  input  logic                cfg_load,
  input  logic [2:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_level,
  input  logic                event_i,
  input  logic                tick,
  input  logic                blink_phase,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] breathe_lvl,
  output logic                led
);

  localparam int unsigned STR_W = (STRETCH_TICKS > 0) ? $clog2(STRETCH_TICKS + 1) : 1;
  localparam logic        LED_INACTIVE = (ACTIVE_LOW != 0);

  logic [2:0]          mode_q, mode_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [STR_W-1:0]    stretch_q, stretch_d;
  logic                led_q, led_d;
  logic                lit;

  // Config load and stretch counter; a fresh event wins over a tick decrement.
  always_comb begin
    mode_d    = mode_q;
    level_d   = level_q;
    stretch_d = stretch_q;
    if (cfg_load) begin
      mode_d  = cfg_mode;
      level_d = cfg_level;
    end
    if (event_i) begin
      stretch_d = STR_W'(STRETCH_TICKS);
    end else if (tick && (stretch_q != '0)) begin
      stretch_d = stretch_q - STR_W'(1);
    end
  end

  // Reserved mode codes fall through to dark.
  always_comb begin
    lit = 1'b0;
    case (mode_q)
      LED_ON:      lit = 1'b1;
      LED_BLINK:   lit = blink_phase;
      LED_PWM:     lit = (pwm_cnt < level_q);
      LED_STRETCH: lit = (stretch_q != '0);
      LED_BREATHE: lit = (pwm_cnt < breathe_lvl);
      default:     lit = 1'b0;
    endcase
    led_d = lit ^ LED_INACTIVE;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      mode_q    <= LED_OFF;
      level_q   <= '0;
      stretch_q <= '0;
      led_q     <= LED_INACTIVE;
    end else begin
      mode_q    <= mode_d;
      level_q   <= level_d;
      stretch_q <= stretch_d;
      led_q     <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel status-LED controller: prescaler plus shared blink, PWM and
// breathe generators feeding one led_channel per output.
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int unsigned NUM_LEDS      = 4,
  parameter int unsigned PWM_BITS      = 4,
  parameter int unsigned PRESCALE      = 50000,
  parameter int unsigned SIM           = 0,
  parameter int unsigned BLINK_TICKS   = 250,
  parameter int unsigned STRETCH_TICKS = 50,
  parameter int unsigned ACTIVE_LOW    = 1,
  localparam int unsigned CHAN_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk_50m,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [2:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_level,
  input  logic [NUM_LEDS-1:0] event_i,
  output logic                tick_o,
  output logic [NUM_LEDS-1:0] led
);

  localparam int unsigned PRESC   = (SIM != 0) ? SIM_PRESCALE : PRESCALE;
  localparam int unsigned PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                tick_q, tick_d;
  logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0] breathe_q, breathe_d;
  logic                breathe_dn_q, breathe_dn_d;

  // Prescaler: tick_o follows the terminal count by one register stage.
  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    tick_d  = 1'b0;
    if (presc_q == PRESC_W'(PRESC - 1)) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end
  end

  // Shared waveforms; breathe holds each end value for one extra tick while turning.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    breathe_d     = breathe_q;
    breathe_dn_d  = breathe_dn_q;
    pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
    if (tick_q) begin
      if (blink_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
      if (!breathe_dn_q) begin
        if (breathe_q == '1) breathe_dn_d = 1'b1;
        else                 breathe_d    = breathe_q + PWM_BITS'(1);
      end else begin
        if (breathe_q == '0) breathe_dn_d = 1'b0;
        else                 breathe_d    = breathe_q - PWM_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      tick_q        <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pwm_cnt_q     <= '0;
      breathe_q     <= '0;
      breathe_dn_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      tick_q        <= tick_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pwm_cnt_q     <= pwm_cnt_d;
      breathe_q     <= breathe_d;
      breathe_dn_q  <= breathe_dn_d;
    end
  end

  assign tick_o = tick_q;

  // Out-of-range channel numbers match no instance, so such writes are dropped.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    led_channel #(
      .PWM_BITS      (PWM_BITS),
      .STRETCH_TICKS (STRETCH_TICKS),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_chan (
      .clk_50m     (clk_50m),
      .rst         (rst),
      .cfg_load    (cfg_we && (cfg_chan == CHAN_W'(i))),
      .cfg_mode    (cfg_mode),
      .cfg_level   (cfg_level),
      .event_i     (event_i[i]),
      .tick        (tick_q),
      .blink_phase (blink_phase_q),
      .pwm_cnt     (pwm_cnt_q),
      .breathe_lvl (breathe_q),
      .led         (led[i])
    );
  end

endmodule
